scan_chain_ctrl: RTL and testbench

//  Sequences a chain of CHAIN_LEN scan flip-flops (ports D/SD/SE/CK/Q) in the masked

---
 rtl/scan_chain_ctrl.sv | 140 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift-in, functional capture, shift-out, parallel result.
// Optional abort input is enabled by defining SCAN_ABORT_EN.
//
// state        | meaning
// S_IDLE       | waiting for start, SE=0
// S_SHIFT_IN   | CHAIN_LEN cycles, SE=1, SD walks load word MSB first
// S_CAPTURE    | CAPTURE_CYCLES functional clocks, SE=0
// S_SHIFT_OUT  | CHAIN_LEN cycles, SE=1, SO collected tail first into dout
// S_DONE       | one-cycle done pulse, result valid
module scan_chain_ctrl #(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 SO,
`ifdef SCAN_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 SE,
    output logic                 SD,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] dout
);

    localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] shadow;
    logic [CHAIN_LEN-1:0] out_sel;
    logic                 abort_req;

`ifdef SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // shadow is a left-shifting copy of the load word: its MSB is always the next SD bit.
    // out_sel is a one-hot pointer to the dout bit written by the current SO sample.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shadow  <= '0;
            out_sel <= '0;
            SE      <= 1'b0;
            SD      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else if (abort_req && (state != S_IDLE)) begin
            state <= S_IDLE;
            cnt   <= '0;
            SE    <= 1'b0;
            SD    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_SHIFT_IN;
                        cnt    <= '0;
                        shadow <= {load_data[CHAIN_LEN-2:0], 1'b0};
                        SE     <= 1'b1;
                        SD     <= load_data[CHAIN_LEN-1];
                        busy   <= 1'b1;
                    end
                end
                S_SHIFT_IN: begin
                    if (cnt == SHIFT_LAST) begin
                        state <= S_CAPTURE;
                        cnt   <= '0;
                        SE    <= 1'b0;
                        SD    <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        SD     <= shadow[CHAIN_LEN-1];
                        shadow <= {shadow[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                S_CAPTURE: begin
                    if (cnt == CAP_LAST) begin
                        state   <= S_SHIFT_OUT;
                        cnt     <= '0;
                        SE      <= 1'b1;
                        SD      <= 1'b0;
                        out_sel <= {1'b1, {(CHAIN_LEN-1){1'b0}}};
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_SHIFT_OUT: begin
                    dout    <= (dout & ~out_sel) | ({CHAIN_LEN{SO}} & out_sel);
                    out_sel <= out_sel >> 1;
                    if (cnt == SHIFT_LAST) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        SE    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    SE    <= 1'b0;
                    SD    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (CAPTURE_CYCLES 1 and 2) each driving a
// 16-cell scan flop model whose functional D is either Q (hold) or ~Q (invert).
module tb_scan_chain_ctrl;

    localparam int N = 16;

    logic         ck = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] load_data;
    logic         abort;
    logic         inv_mode;
    bit           sel;

    logic         se1, sd1, busy1, done1, so1;
    logic [N-1:0] dout1, chain1;
    logic         se2, sd2, busy2, done2, so2;
    logic [N-1:0] dout2, chain2;

    logic         se_m, sd_m, busy_m, done_m;
    logic [N-1:0] dout_m;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] sb_q[$];

    always #5 ck = ~ck;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) u_dut1 (
        .CK(ck), .RST(rst), .start(start), .load_data(load_data), .SO(so1),
`ifdef SCAN_ABORT_EN
        .abort(abort),
`endif
        .SE(se1), .SD(sd1), .busy(busy1), .done(done1), .dout(dout1)
    );

    scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(2)) u_dut2 (
        .CK(ck), .RST(rst), .start(start), .load_data(load_data), .SO(so2),
`ifdef SCAN_ABORT_EN
        .abort(abort),
`endif
        .SE(se2), .SD(sd2), .busy(busy2), .done(done2), .dout(dout2)
    );

    // Scan flop chains: cell 0 takes SD, tail drives SO.
    always_ff @(posedge ck) begin
        chain1 <= se1 ? {chain1[N-2:0], sd1} : (inv_mode ? ~chain1 : chain1);
        chain2 <= se2 ? {chain2[N-2:0], sd2} : (inv_mode ? ~chain2 : chain2);
    end
    assign so1 = chain1[N-1];
    assign so2 = chain2[N-1];

    assign se_m   = sel ? se2   : se1;
    assign sd_m   = sel ? sd2   : sd1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;
    assign dout_m = sel ? dout2 : dout1;

    typedef struct {
        logic [N-1:0] load;
        bit           inv;
        bit           sel;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int poke, output int cyc, output int se_hi,
                             output int se_lo, output bit seen);
        cyc = 0; se_hi = 0; se_lo = 0; seen = 1'b0;
        while (cyc < 100) begin
            if (done_m) begin
                seen = 1'b1;
                break;
            end
            if (se_m) se_hi++; else se_lo++;
            if (poke >= 0) begin
                start = (cyc == poke);
                if (cyc == poke) load_data = 16'h1234;
            end
            @(negedge ck);
            cyc++;
        end
    endtask

    task automatic check_done(input bit seen);
        logic [N-1:0] exp;
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("busy_in_done", 32'(busy_m), 32'd1);
            if (sb_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check("dout", 32'(dout_m), 32'(exp));
            end
        end
    endtask

    task automatic run_op(input logic [N-1:0] val, input logic [N-1:0] exp, input int poke);
        int cyc, se_hi, se_lo, bad;
        bit seen;
        int cap;
        cap = sel ? 2 : 1;
        repeat (3) @(negedge ck);
        start = 1'b1; load_data = val;
        sb_q.push_back(exp);
        @(negedge ck);
        start = 1'b0; load_data = 16'($urandom);
        check("busy_after_accept", 32'(busy_m), 32'd1);
        wait_done(poke, cyc, se_hi, se_lo, seen);
        if (seen && poke == cyc) begin
            start = 1'b1; load_data = 16'h1234;
        end
        check_done(seen);
        check("latency", 32'(cyc), 32'(2 * N + cap));
        check("se_high_cycles", 32'(se_hi), 32'(2 * N));
        check("se_low_cycles", 32'(se_lo), 32'(cap));
        @(negedge ck);
        start = 1'b0;
        check("busy_after_done", 32'(busy_m), 32'd0);
        check("done_pulse_width", 32'(done_m), 32'd0);
        bad = 0;
        repeat (4) begin
            @(negedge ck);
            if (busy_m || done_m) bad++;
        end
        check("no_second_op", 32'(bad), 32'd0);
        check("dout_stable_after", 32'(dout_m), 32'(exp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, se_hi, se_lo;
        bit seen;

        vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 16'hA5C3};
        vecs[1] = '{16'h00FF, 1'b1, 1'b0, 16'hFF00};
        vecs[2] = '{16'h00FF, 1'b1, 1'b1, 16'h00FF};
        vecs[3] = '{16'h1234, 1'b1, 1'b0, 16'hEDCB};
        vecs[4] = '{16'h8001, 1'b0, 1'b0, 16'h8001};
        vecs[5] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF};
        vecs[6] = '{16'h0F0F, 1'b1, 1'b1, 16'h0F0F};
        vecs[7] = '{16'h0000, 1'b1, 1'b0, 16'hFFFF};

        rst = 1'b1; start = 1'b0; load_data = '0; abort = 1'b0;
        inv_mode = 1'b0; sel = 1'b0;
        repeat (2) @(negedge ck);
        check("reset_se", 32'(se_m), 32'd0);
        check("reset_sd", 32'(sd_m), 32'd0);
        check("reset_busy", 32'(busy_m), 32'd0);
        check("reset_done", 32'(done_m), 32'd0);
        check("reset_dout", 32'(dout_m), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel;
            inv_mode = vecs[i].inv;
            run_op(vecs[i].load, vecs[i].exp, -1);
        end

        // start pulses during SHIFT_OUT and during the DONE cycle are ignored
        sel = 1'b0; inv_mode = 1'b0;
        run_op(16'hC0DE, 16'hC0DE, 20);
        run_op(16'h6B3D, 16'h6B3D, 2 * N + 1);

        // start held high: one idle cycle, then re-accepted
        repeat (3) @(negedge ck);
        start = 1'b1; load_data = 16'h5A5A;
        sb_q.push_back(16'h5A5A);
        @(negedge ck);
        wait_done(-1, cyc, se_hi, se_lo, seen);
        check_done(seen);
        @(negedge ck);
        check("held_idle_gap", 32'(busy_m), 32'd0);
        @(negedge ck);
        check("held_reaccept", 32'(busy_m), 32'd1);
        start = 1'b0;
        sb_q.push_back(16'h5A5A);
        wait_done(-1, cyc, se_hi, se_lo, seen);
        check_done(seen);
        check("held_latency", 32'(cyc), 32'(2 * N + 1));
        @(negedge ck);

        // RST in SHIFT_IN cycle 7
        repeat (2) @(negedge ck);
        start = 1'b1; load_data = 16'hABCD;
        @(negedge ck);
        start = 1'b0;
        repeat (7) @(negedge ck);
        check("pre_reset_busy", 32'(busy_m), 32'd1);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        check("midrst_se", 32'(se_m), 32'd0);
        check("midrst_sd", 32'(sd_m), 32'd0);
        check("midrst_busy", 32'(busy_m), 32'd0);
        check("midrst_done", 32'(done_m), 32'd0);
        check("midrst_dout", 32'(dout_m), 32'd0);

        // RST and start together: start lost
        rst = 1'b1; start = 1'b1; load_data = 16'h1111;
        @(negedge ck);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", 32'(busy_m), 32'd0);
        @(negedge ck);
        check("rst_beats_start_later", 32'(busy_m), 32'd0);

        run_op(16'hBEEF, 16'hBEEF, -1);

`ifdef SCAN_ABORT_EN
        sel = 1'b0; inv_mode = 1'b0;
        run_op(16'h3C3C, 16'h3C3C, -1);
        start = 1'b1; load_data = 16'hFFFF;
        @(negedge ck);
        start = 1'b0;
        repeat (N) @(negedge ck);
        check("abort_in_capture_se", 32'(se_m), 32'd0);
        abort = 1'b1;
        @(negedge ck);
        abort = 1'b0;
        check("abort_se", 32'(se_m), 32'd0);
        check("abort_sd", 32'(sd_m), 32'd0);
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_done", 32'(done_m), 32'd0);
        check("abort_dout_held", 32'(dout_m), 32'h3C3C);
        begin
            int bad;
            bad = 0;
            repeat (40) begin
                @(negedge ck);
                if (busy_m || done_m) bad++;
            end
            check("abort_no_done", 32'(bad), 32'd0);
        end
`endif

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
